// File: rtl/conv_sched.sv
// Sliding-window / kernel-bank sequencer feeding one combinational conv instance.
// Optional CONV_SCHED_RELU_EN: clamp negative conv results to zero at capture.
module conv_sched #(
  parameter int IN_WIDTH     = 12,
  parameter int WEIGHT_WIDTH = 12,
  parameter int OUT_WIDTH    = 12,
  parameter int N            = 5,
  parameter int C_OUT        = 4,
  parameter int CH_W         = $clog2(C_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      w_we,
  input  logic [CH_W-1:0]           w_addr,
  input  logic [N*WEIGHT_WIDTH-1:0] w_data,
  output logic                      w_ready,
  output logic [N*IN_WIDTH-1:0]     conv_x,
  output logic [N*WEIGHT_WIDTH-1:0] conv_h,
  input  logic [OUT_WIDTH-1:0]      conv_y,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int FILL_W = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FULL      = FILL_W'(N);
  localparam logic [FILL_W-1:0] FULL_M1   = FILL_W'(N - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(C_OUT - 1);
  localparam logic [CH_W:0]     NUM_BANKS = (CH_W + 1)'(C_OUT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic [IN_WIDTH-1:0]       win  [N];
  logic [N*WEIGHT_WIDTH-1:0] bank [C_OUT];
  logic [FILL_W-1:0]         fill_cnt;
  logic [CH_W-1:0]           ch;
  logic                      accept;
  logic                      capture;
  logic                      bank_we;
  logic [OUT_WIDTH-1:0]      cap_data;

`ifdef CONV_SCHED_RELU_EN
  assign cap_data = conv_y[OUT_WIDTH-1] ? '0 : conv_y;
`else
  assign cap_data = conv_y;
`endif

  for (genvar l = 0; l < N; l++) begin : g_pack
    assign conv_x[l*IN_WIDTH +: IN_WIDTH] = win[l];
  end

  assign conv_h  = bank[ch];
  assign bank_we = w_we && w_ready && ({1'b0, w_addr} < NUM_BANKS);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    w_ready   = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        w_ready  = 1'b1;
        accept   = in_valid;
        if (in_valid && fill_cnt >= FULL_M1) state_nxt = RUN;
      end
      RUN: begin
        capture = !out_valid || out_ready;
        if (capture && ch == LAST_CH) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) state <= IDLE;
    else               state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int l = 0; l < N; l++) win[l] <= '0;
      fill_cnt  <= '0;
      ch        <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int l = 0; l < N - 1; l++) win[l] <= win[l+1];
        win[N-1] <= in_data;
        fill_cnt <= (fill_cnt == FULL) ? FULL : fill_cnt + 1'b1;
      end
      if (capture) begin
        out_data  <= cap_data;
        out_ch    <= ch;
        out_last  <= (ch == LAST_CH);
        out_valid <= 1'b1;
        ch        <= (ch == LAST_CH) ? '0 : ch + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the kernel bank is a small register array that must read as zero after reset, so it is reset explicitly; clr leaves it intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < C_OUT; k++) bank[k] <= '0;
    end else if (bank_we) begin
      bank[w_addr] <= w_data;
    end
  end

endmodule
